// File: rtl/nios2_c_onchip_wr_pkg.sv
// Shared definitions for the on-chip memory stream writer.
// Holds the FSM state type and the widths used by the top, the packer
// and the bus interface. No ports.
package nios2_c_onchip_wr_pkg;

  localparam int ADDR_W    = 17;
  localparam int CNT_W     = 19;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int MEM_WORDS = 75000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nios2_c_onchip_stream_writer_if.sv
// Stream-in and memory-write-port bundle for the stream writer.
// Signals: in_valid/in_data/in_ready (byte stream), m_address,
// m_byteenable, m_chipselect, m_write, m_writedata, m_grant (memory port).
// master: the loader (drives in_ready and m_*). slave: stream source,
// memory and arbiter side.
interface nios2_c_onchip_stream_writer_if;
  import nios2_c_onchip_wr_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_grant;

  modport master (
    input  in_valid, in_data, m_grant,
    output in_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata
  );

  modport slave (
    output in_valid, in_data, m_grant,
    input  in_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata
  );

endinterface

// File: rtl/nios2_c_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports: clk, reset (async, active-high); load stores in_data into the
// current lane; clear empties the buffer after a word is written.
// data_nxt/be_nxt give the word as it will look after this cycle's load,
// so the caller can capture a finished word on the same edge.
// full is high while the next byte goes into lane 3.
module nios2_c_byte_packer
  import nios2_c_onchip_wr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [7:0]        in_data,
  output logic [DATA_W-1:0] data_nxt,
  output logic [BE_W-1:0]   be_nxt,
  output logic              full
);

  logic [1:0]        lane_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;

  always_comb begin
    data_nxt = data_q;
    be_nxt   = be_q;
    if (load) begin
      data_nxt[{lane_q, 3'b000} +: 8] = in_data;
      be_nxt[lane_q]                  = 1'b1;
    end
  end

  assign full = (lane_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= 2'd0;
      data_q <= '0;
      be_q   <= '0;
    end else if (clear) begin
      lane_q <= 2'd0;
      data_q <= '0;
      be_q   <= '0;
    end else if (load) begin
      lane_q <= lane_q + 2'd1;
      data_q <= data_nxt;
      be_q   <= be_nxt;
    end
  end

endmodule

// File: rtl/nios2_c_onchip_stream_writer.sv
// Byte-stream loader for the on-chip program/data memory.
// Packs a software-started job of byte_count bytes into 32-bit words and
// writes them from base_addr upward, one word per arbiter grant.
// Ports: clk, reset (async, active-high), start/base_addr/byte_count (job
// request), bus (stream in + memory write port, master side), busy, done
// (one-cycle end pulse), error (sticky range error), checksum.
// Option macro ONCHIP_WR_CHECKSUM_EN: builds the running word-sum
// accumulator; without it checksum is tied to zero.
module nios2_c_onchip_stream_writer
  import nios2_c_onchip_wr_pkg::*;
#(
  parameter int MEM_WORDS = nios2_c_onchip_wr_pkg::MEM_WORDS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [CNT_W-1:0]                     byte_count,
  nios2_c_onchip_stream_writer_if.master       bus,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [DATA_W-1:0]                    checksum
);

  // One bit wider than the byte count so base + words cannot overflow.
  localparam int RC_W = CNT_W + 1;

  state_t            state_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              xfer;
  logic              last_byte;
  logic              granted;
  logic [DATA_W-1:0] data_nxt;
  logic [BE_W-1:0]   be_nxt;
  logic              lane_full;
  logic [RC_W-1:0]   words_needed;
  logic [RC_W-1:0]   range_end;
  logic              range_err;

  assign words_needed = (RC_W'(byte_count) + RC_W'(3)) >> 2;
  assign range_end    = RC_W'(base_addr) + words_needed;
  assign range_err    = (range_end > RC_W'(MEM_WORDS));

  assign xfer      = bus.in_valid & bus.in_ready;
  assign last_byte = lane_full | (remaining_q == CNT_W'(1));
  // m_write is only ever high in WRITE, so this marks the completing edge.
  assign granted   = bus.m_write & bus.m_grant;

  nios2_c_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .load     (xfer),
    .clear    (granted),
    .in_data  (bus.in_data),
    .data_nxt (data_nxt),
    .be_nxt   (be_nxt),
    .full     (lane_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      remaining_q      <= '0;
      bus.in_ready     <= 1'b0;
      bus.m_address    <= '0;
      bus.m_byteenable <= '0;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_writedata  <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bus.m_address <= base_addr;
            remaining_q   <= byte_count;
            error         <= 1'b0;
            busy          <= 1'b1;
            if (byte_count == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else if (range_err) begin
              error   <= 1'b1;
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q      <= FILL;
              bus.in_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (xfer) begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (last_byte) begin
              // Capture the finished word; it stays put until granted.
              state_q          <= WRITE;
              bus.in_ready     <= 1'b0;
              bus.m_chipselect <= 1'b1;
              bus.m_write      <= 1'b1;
              bus.m_writedata  <= data_nxt;
              bus.m_byteenable <= be_nxt;
            end
          end
        end
        WRITE: begin
          if (bus.m_grant) begin
            bus.m_address    <= bus.m_address + ADDR_W'(1);
            bus.m_chipselect <= 1'b0;
            bus.m_write      <= 1'b0;
            if (remaining_q != '0) begin
              state_q      <= FILL;
              bus.in_ready <= 1'b1;
            end else begin
              state_q <= DONE;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ONCHIP_WR_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Expand byte enables to a bit mask so disabled lanes add as zero.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      checksum_q <= '0;
    end else if (granted) begin
      checksum_q <= checksum_q + (bus.m_writedata & lane_mask(bus.m_byteenable));
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios2_c_onchip_stream_writer.sv
module tb_nios2_c_onchip_stream_writer;
  import nios2_c_onchip_wr_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  byte_count;
  logic              busy, done, error;
  logic [31:0]       checksum;

  always #5 clk = ~clk;

  nios2_c_onchip_stream_writer_if bus();

  nios2_c_onchip_stream_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .byte_count (byte_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] byte_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_wr_cyc = -10;
  int         stall_cnt = 0;
  int         stall_left = 0;
  bit         saw_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Arbiter: holds grant low for stall_left cycles of each write.
  initial begin
    bus.m_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_write && stall_left > 0) begin
        bus.m_grant = 1'b0;
        stall_left--;
      end else begin
        bus.m_grant = 1'b1;
      end
    end
  end

  // Compare process: every completed write against the model queue,
  // and held outputs while grant is low.
  initial begin
    wr_t  w;
    logic [ADDR_W-1:0] s_a;
    logic [31:0] s_d;
    logic [3:0]  s_be;
    bit          s_vld;
    s_vld = 0;
    s_a = '0; s_d = '0; s_be = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        s_vld = 0;
      end else begin
        if (bus.in_ready) saw_ready = 1;
        if (bus.m_write !== bus.m_chipselect)
          chk("cs_eq_write", {31'd0, bus.m_chipselect}, {31'd0, bus.m_write});
        if (bus.m_write) begin
          if (bus.in_ready) chk("ready_in_write", 32'd1, 32'd0);
          if (s_vld) begin
            chk("stall_addr", 32'(bus.m_address), 32'(s_a));
            chk("stall_data", bus.m_writedata, s_d);
            chk("stall_be", 32'(bus.m_byteenable), 32'(s_be));
          end
          if (bus.m_grant) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 32'(bus.m_address), 32'hFFFF_FFFF);
            end else begin
              w = exp_q.pop_front();
              chk("wr_addr", 32'(bus.m_address), 32'(w.a));
              chk("wr_data", bus.m_writedata, w.d);
              chk("wr_be", 32'(bus.m_byteenable), 32'(w.be));
            end
            last_wr_cyc = cyc;
            s_vld = 0;
          end else begin
            stall_cnt++;
            s_a = bus.m_address; s_d = bus.m_writedata; s_be = bus.m_byteenable;
            s_vld = 1;
          end
        end
      end
    end
  end

  // Model: words from byte_q, little-endian, partial last word.
  logic [31:0] md[64];
  logic [3:0]  mbe[64];
  int          mnw;
  logic [31:0] mck;
  bit          merr;

  task automatic build_model(input int base);
    int nb;
    nb = byte_q.size();
    for (int i = 0; i < 64; i++) begin md[i] = '0; mbe[i] = '0; end
    for (int i = 0; i < nb; i++) begin
      md[i/4][(i%4)*8 +: 8] = byte_q[i];
      mbe[i/4][i%4] = 1'b1;
    end
    mnw  = (nb + 3) / 4;
    merr = (base + mnw) > 75000;
    mck  = '0;
    if (!merr) begin
      for (int i = 0; i < mnw; i++) begin
        mck = mck + md[i];
        exp_q.push_back('{a: ADDR_W'(base + i), d: md[i], be: mbe[i]});
      end
    end
  endtask

  task automatic feed_bytes(input int n);
    int idx, guard;
    bit x;
    idx = 0; guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = byte_q[0];
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      x = bus.in_ready;
      @(posedge clk);
      #1;
      if (x) begin
        idx++;
        if (idx < n) bus.in_data = byte_q[idx];
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 1000) chk("feed_timeout", 32'(idx), 32'(n));
  endtask

  task automatic run_job(input int base, input int stall);
    int nb, g;
    bit writes;
    logic [31:0] ck_req;
    nb = byte_q.size();
    build_model(base);
    writes = (nb != 0) && !merr;
    saw_ready = 0; stall_cnt = 0; stall_left = stall;
    base_addr = ADDR_W'(base); byte_count = CNT_W'(nb); start = 1'b1;
    step();
    start = 1'b0;
    chk("ready_after_start", {31'd0, bus.in_ready}, {31'd0, writes});
    if (writes) feed_bytes(nb);
    g = 0;
    @(negedge clk);
    while (done !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (writes) chk("done_after_last_wr", 32'(cyc), 32'(last_wr_cyc + 1));
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("error", {31'd0, error}, {31'd0, merr});
`ifdef ONCHIP_WR_CHECKSUM_EN
    ck_req = mck;
`else
    ck_req = 32'h0;
`endif
    chk("checksum", checksum, ck_req);
    @(negedge clk);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("stall_cycles", 32'(stall_cnt), 32'(stall));
    chk("ready_seen", {31'd0, saw_ready}, {31'd0, writes});
    exp_q.delete();
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_cs"}, {31'd0, bus.m_chipselect}, 32'd0);
    chk({tag, "_write"}, {31'd0, bus.m_write}, 32'd0);
    chk({tag, "_addr"}, 32'(bus.m_address), 32'd0);
    chk({tag, "_be"}, 32'(bus.m_byteenable), 32'd0);
    chk({tag, "_wdata"}, bus.m_writedata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // 8 bytes at 0x10; pin the model with hand values.
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_model(16);
    chk("model_w0", md[0], 32'h04030201);
    chk("model_w1", md[1], 32'h08070605);
    chk("model_ck", mck, 32'h0C0A0806);
    exp_q.delete();
    run_job(16, 0);

    // Partial last word.
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    build_model(256);
    chk("model_p1", md[1], 32'h000000EE);
    chk("model_p1be", 32'(mbe[1]), 32'h1);
    exp_q.delete();
    run_job(256, 0);

    // Grant low for 10 cycles.
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_job(32, 10);

    // Out of range, then recovery.
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_job(74999, 0);
    byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_job(0, 0);

    // Exactly reaching the last word is legal.
    byte_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    run_job(74998, 3);

    // Zero-length job.
    byte_q.delete();
    run_job(5, 0);

    // Reset after 2 of 4 bytes: no write, then a clean job.
    byte_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    exp_q.delete();
    base_addr = ADDR_W'(48); byte_count = CNT_W'(4); start = 1'b1;
    step();
    start = 1'b0;
    feed_bytes(2);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step();
    reset = 1'b0;
    step();
    byte_q = '{8'h01, 8'h02, 8'h03};
    run_job(64, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/nios2_c_onchip_stream_writer.md
# nios2_c_onchip_stream_writer

Upstream loader for the on-chip program/data memory. Accepts a byte stream (UART/SPI receive path), packs bytes little-endian into 32-bit words, and issues single-cycle word writes with byte enables into the memory's write port. Each transfer is a software-started job of N bytes at a word base address. It runs under an external arbiter grant so the CPU data master and the loader share the port.

## Interface
- MEM_WORDS, 75000, memory depth in 32-bit words; last legal word address is MEM_WORDS-1
- ADDR_W, 17, word-address width
- CNT_W, 19, byte-count width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle job start; honoured only in IDLE
- base_addr  in  ADDR_W  first word address; sampled on accepted start
- byte_count  in  CNT_W  job length in bytes; sampled on accepted start
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- m_address  out  ADDR_W  memory word address
- m_byteenable  out  4  byte lanes to write
- m_chipselect  out  1  memory select
- m_write  out  1  write strobe
- m_writedata  out  32  packed word
- m_grant  in  1  arbiter grant; a write completes on a rising edge where m_chipselect & m_write & m_grant
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky range error; cleared by the next accepted start
- checksum  out  32  running word sum (see Configuration)

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: busy=0, in_ready=0. On start, latch base_addr into the address counter and byte_count into the remaining counter, clear error, clear checksum.
  - byte_count==0: go to DONE. No write.
  - words_needed = ceil(byte_count/4). If base_addr + words_needed > MEM_WORDS: set error, go to DONE, no write.
  - Otherwise go to FILL.
- FILL: in_ready=1. Each transfer stores in_data in lane k = bytes_in_word (0..3), so the first byte lands in bits 7:0. It sets byteenable bit k and decrements remaining.
  - Go to WRITE on the transfer that fills lane 3 or brings remaining to 0.
- WRITE: in_ready=0. m_chipselect=m_write=1, with address, byteenable and data held stable until granted.
  - On the granted edge: address +1, lane buffer and enables cleared, checksum += writedata with disabled lanes as 0 (mod 2^32).
  - Then go to FILL if remaining>0, else DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- A partial final word writes only its valid lanes. For example, 6 bytes produce word0 with be=4'hF, then word1 with be=4'h3.
- start outside IDLE is ignored.
- Address never wraps. The range check guarantees the last write address is ≤ MEM_WORDS-1.
- Outside WRITE, m_chipselect and m_write are 0. m_address, m_writedata and m_byteenable hold their last values (don't-care to the memory).

## Timing
- Reset values: in_ready=0, m_chipselect=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, busy=0, done=0, error=0, checksum=0; state IDLE.
- Reset mid-job: everything returns to the reset values immediately. The partial word is discarded and no write is issued.
- start→first in_ready: 1 cycle (IDLE→FILL edge).
- Full word with continuous in_valid and m_grant held high: 4 FILL cycles + 1 WRITE cycle = 5 cycles per word.
- Grant low stalls in WRITE indefinitely with outputs stable. There is no timeout.
- Last granted write → done pulse on the next cycle → busy=0 the cycle after.
- busy is 1 in FILL, WRITE and DONE.
- All outputs are registered; no input→output combinational path except none (in_ready derives from state only).

## Configuration
- ONCHIP_WR_CHECKSUM_EN defined: the checksum accumulator is built and checksum reports the sum of all words written by the current/last job. Software reads it after done.
- Not defined: no accumulator logic; the checksum port remains and is tied to 32'h0.

## Structure
- Package nios2_c_onchip_wr_pkg holds:
  - state enum (IDLE, FILL, WRITE, DONE)
  - ADDR_W, CNT_W, DATA_W=32, BE_W=4
  - MEM_WORDS default
- Sub-module nios2_c_byte_packer holds the lane index, the data/byteenable shift-in, and the full/last indication. The top keeps the FSM, counters, range check and checksum.

## Test plan
- base_addr=0x00010, byte_count=8, bytes 01..08, grant tied 1 → writes [0x10]=0x04030201 be=F and [0x11]=0x08070605 be=F; done 1 cycle after the second write; checksum=0x0C0A0806 with the macro, 0 without.
- byte_count=5, bytes AA BB CC DD EE → second write 0x000000EE be=4'h1 at base+1.
- Grant held low for 10 cycles in WRITE → m_* stable for all 10 cycles, in_ready=0, exactly one write on grant.
- base_addr=74999, byte_count=8 → error=1, done pulse, no m_write; next start with base 0, count 4 → error cleared, one write.
- byte_count=0 → done one cycle after start, no write, in_ready never high.
- Reset asserted after 2 bytes of a 4-byte job → all outputs at reset values next edge, no write; a new job then completes normally.
